prbs_chk: RTL and testbench
===========================

# prbs_chk

Hardware PRBS15 stream checker that sits on the receive side of the test wrapper's data path. It is the consumer counterpart of the stimulus/generator side. It seeds itself from the incoming stream, predicts every following word, counts bit errors and loss-of-lock events, and raises `done_o`/`pass_o` after a programmed number of checked words. The bench then samples a single verdict instead of comparing data itself.

## Interface
Parameters:
- `DATA_W`, 8: bits per word, legal range 1–32.
- `NUM_WORDS`, 4096: number of checked words per run, range 1 to 2^32−1.
- `LOSS_THR`, 4: consecutive erroneous words that declare loss of lock.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst`, in, 1: **asynchronous, active-high reset**.
- `start_i`, in, 1: one-cycle pulse that begins or restarts a run.
- `valid_i`, in, 1: `data_i` is valid this cycle.
- `data_i`, in, `DATA_W`: received word; the MSB is the oldest bit.
- `locked_o`, out, 1: high while in CHECK.
- `done_o`, out, 1: run complete; held high until the next `start_i`.
- `pass_o`, out, 1: meaningful only when `done_o` is high. It is 1 iff `err_cnt_o` is 0 and `lost_cnt_o` is 0.
- `err_cnt_o`, out, 32: accumulated mismatching bits; saturates at 0xFFFF_FFFF.
- `lost_cnt_o`, out, 16: loss-of-lock events; saturates at 0xFFFF.
- `word_cnt_o`, out, 32: words checked while in CHECK.

## Operation
- **Generator:** Fibonacci PRBS15, x^15+x^14+1. The new bit is `s[14]^s[13]`, the register shifts left, and `s[0]` takes the new bit. One word is `DATA_W` successive new bits, MSB first.
- **State IDLE:**
  - All outputs except `done_o`/`pass_o` hold their values.
  - `start_i` clears all counters, `done_o` and `pass_o`, then moves to SEED.
- **State SEED:**
  - Each valid word is shifted into the 15-bit state, MSB first.
  - After `ceil(15/DATA_W)` valid words the state holds the last 15 received bits.
  - If that state is all-zero, the checker stays in SEED and counts the seed words again.
  - Otherwise it moves to CHECK. Seed words are not checked or counted.
- **State CHECK:** for each valid word:
  - The predicted word is computed from the current state.
  - `err_cnt_o` increases by popcount(`data_i` ^ predicted), saturating.
  - `word_cnt_o` increments.
  - The state advances using the predicted bits, never the received bits.
  - A word with one or more errors increments the consecutive-error counter; an error-free word clears it.
- **Loss of lock:** when the consecutive-error counter reaches `LOSS_THR`:
  - `lost_cnt_o` increments.
  - The consecutive-error counter clears.
  - The checker moves to LOST.
- **State LOST:** behaviour depends on configuration (see Configuration).
- **State DONE:** entered when `word_cnt_o` reaches `NUM_WORDS`.
  - `done_o` is set to 1 and `pass_o` is evaluated.
  - Further `valid_i` is ignored.
  - `start_i` starts a new run.
- **`start_i` in any state:** starts a new run exactly as from IDLE. This takes priority over a concurrent valid word.
- **No backpressure:** the checker is always ready, and cycles with `valid_i` low change no state.

## Timing
- **Reset values:** the FSM is in IDLE; the LFSR is 0; every output and counter is 0.
- **Latency:** all outputs are registered. Counters reflect a valid word 1 cycle after that word is sampled.
- **Lock timing:** `locked_o` rises in the cycle after the final seed word.
- **Done on final word:** `done_o` rises 1 cycle after the `NUM_WORDS`-th checked word. The final word's errors are included in the `pass_o` computed on that same edge.
- **Loss of lock and done together:** if loss of lock and the `NUM_WORDS`-th word occur on the same word, DONE wins. `lost_cnt_o` still increments and `pass_o` = 0.
- **Reset mid-run:** asynchronous return to reset values; there is no partial verdict.

## Configuration
- **Macro `PRBS_CHK_RELOCK_EN`:**
  - Defined: LOST moves to SEED on the next cycle and checking resumes automatically. `word_cnt_o` continues from its value.
  - Undefined: LOST is terminal. `locked_o` = 0, `done_o` is set to 1 and `pass_o` = 0 on the next cycle, and only `start_i` leaves the state.

## Structure
- **Package `prbs_pkg`:**
  - FSM state enum: IDLE, SEED, CHECK, LOST, DONE.
  - PRBS order 15 and the tap positions 14 and 13.
  - Counter widths 32 and 16.
  - A function computing the seed word count, `ceil(15/DATA_W)`.
- **Sub-module `prbs15_step`:** combinational. Given a state and `DATA_W`, it returns the next state and the predicted word. It is also reusable by the generator side.

## Test plan
1. **Error-free run:** reset, `start_i`, then a clean PRBS15 stream with seed 0x7FFF, `DATA_W`=8, `NUM_WORDS`=16. Expect `locked_o` after 2 words, `done_o`=1 one cycle after the 18th word, `pass_o`=1, `err_cnt_o`=0.
2. **Single-bit error:** same stream with bit 3 of the 5th checked word flipped. Expect `err_cnt_o`=1, `lost_cnt_o`=0, `pass_o`=0.
3. **Loss of lock with relock:** 4 consecutive all-ones corrupted words, relock enabled, `LOSS_THR`=4. Expect `lost_cnt_o`=1, re-seeding, lock regained 2 words later, `pass_o`=0 at done.
4. **All-zero stream:** feed only 0x00 words. Expect the checker to stay in SEED indefinitely with `locked_o`=0 and `word_cnt_o`=0.
5. **Restart mid-check:** `start_i` pulsed after 7 checked words. Expect all counters at 0 on the next cycle and the checker in SEED.
6. **Reset mid-run:** assert `rst` during CHECK. Expect every output at 0 immediately without waiting for a clock edge, and the checker in IDLE.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared types, constants and helpers for the PRBS15 checker and step function.
package prbs_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEED,
      CHECK,
      LOST,
      DONE
   } state_t;

   localparam int unsigned PRBS_ORDER = 15;
   localparam int unsigned TAP_A      = 14;
   localparam int unsigned TAP_B      = 13;
   localparam int unsigned ERR_W      = 32;
   localparam int unsigned LOST_W     = 16;

   // Number of received words needed to fill the generator state.
   function automatic int unsigned seed_words(input int unsigned data_w);
      return (PRBS_ORDER + data_w - 1) / data_w;
   endfunction

endpackage

// File: rtl/prbs15_step.sv
// Combinational PRBS15 (x^15+x^14+1) word step: emits DATA_W new bits MSB first
// and the generator state after those bits.
module prbs15_step
   import prbs_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [PRBS_ORDER-1:0] state,
   output logic [PRBS_ORDER-1:0] next_state,
   output logic [DATA_W-1:0]     word
);

   logic [PRBS_ORDER-1:0] s;
   logic                  nb;

   always_comb begin
      s    = state;
      nb   = 1'b0;
      word = '0;
      for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
         nb      = s[TAP_A] ^ s[TAP_B];
         word[i] = nb;
         s       = {s[PRBS_ORDER-2:0], nb};
      end
      next_state = s;
   end

endmodule

// File: rtl/prbs_chk.sv
// PRBS15 receive-side checker: self-seeds, predicts, counts bit errors and lock losses.
// Define PRBS_CHK_RELOCK_EN to re-seed automatically after loss of lock.
module prbs_chk
   import prbs_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned NUM_WORDS = 4096,
   parameter int unsigned LOSS_THR  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              locked_o,
   output logic              done_o,
   output logic              pass_o,
   output logic [ERR_W-1:0]  err_cnt_o,
   output logic [LOST_W-1:0] lost_cnt_o,
   output logic [31:0]       word_cnt_o
);

   localparam int unsigned POP_W  = $clog2(DATA_W + 1);
   localparam int unsigned SEED_N = seed_words(DATA_W);
   localparam int unsigned SEED_W = 4;
   localparam int unsigned CONS_W = 16;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned SUM_W  = ERR_W + 1;

   state_t                state;
   logic [PRBS_ORDER-1:0] lfsr;
   logic [PRBS_ORDER-1:0] step_next;
   logic [PRBS_ORDER-1:0] seed_next;
   logic [DATA_W-1:0]     pred;
   logic [POP_W-1:0]      bit_errs;
   logic [SEED_W-1:0]     seed_cnt;
   logic [CONS_W-1:0]     cons_cnt;
   logic [SUM_W-1:0]      err_sum;
   logic [ERR_W-1:0]      err_nxt;
   logic [LOST_W-1:0]     lost_inc;
   logic                  loss_hit;
   logic                  last_word;

   prbs15_step #(.DATA_W(DATA_W)) u_step (
      .state      (lfsr),
      .next_state (step_next),
      .word       (pred)
   );

   // Received bits shift in MSB first; the newest PRBS_ORDER bits form the seed.
   assign seed_next = PRBS_ORDER'({lfsr, data_i});

   always_comb begin
      bit_errs = '0;
      for (int i = 0; i < int'(DATA_W); i++) begin
         bit_errs = bit_errs + POP_W'(data_i[i] ^ pred[i]);
      end
   end

   assign err_sum   = {1'b0, err_cnt_o} + SUM_W'(bit_errs);
   assign err_nxt   = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
   assign lost_inc  = (lost_cnt_o == '1) ? lost_cnt_o : lost_cnt_o + LOST_W'(1);
   assign loss_hit  = (bit_errs != '0) && ((cons_cnt + CONS_W'(1)) == CONS_W'(LOSS_THR));
   assign last_word = (word_cnt_o + WORD_W'(1)) == WORD_W'(NUM_WORDS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         lfsr       <= '0;
         seed_cnt   <= '0;
         cons_cnt   <= '0;
         locked_o   <= 1'b0;
         done_o     <= 1'b0;
         pass_o     <= 1'b0;
         err_cnt_o  <= '0;
         lost_cnt_o <= '0;
         word_cnt_o <= '0;
      end else if (start_i) begin
         state      <= SEED;
         lfsr       <= '0;
         seed_cnt   <= '0;
         cons_cnt   <= '0;
         locked_o   <= 1'b0;
         done_o     <= 1'b0;
         pass_o     <= 1'b0;
         err_cnt_o  <= '0;
         lost_cnt_o <= '0;
         word_cnt_o <= '0;
      end else begin
         case (state)
            IDLE: ;
            SEED: begin
               if (valid_i) begin
                  lfsr <= seed_next;
                  if (seed_cnt == SEED_W'(SEED_N - 1)) begin
                     seed_cnt <= '0;
                     // An all-zero seed is the PRBS lock-up state; keep seeding.
                     if (seed_next != '0) begin
                        state    <= CHECK;
                        locked_o <= 1'b1;
                     end
                  end else begin
                     seed_cnt <= seed_cnt + SEED_W'(1);
                  end
               end
            end
            CHECK: begin
               if (valid_i) begin
                  lfsr       <= step_next;
                  err_cnt_o  <= err_nxt;
                  word_cnt_o <= word_cnt_o + WORD_W'(1);
                  cons_cnt   <= ((bit_errs == '0) || loss_hit) ? '0 : cons_cnt + CONS_W'(1);
                  if (loss_hit) begin
                     lost_cnt_o <= lost_inc;
                  end
                  if (last_word) begin
                     state    <= DONE;
                     locked_o <= 1'b0;
                     done_o   <= 1'b1;
                     pass_o   <= (err_nxt == '0) && !loss_hit && (lost_cnt_o == '0);
                  end else if (loss_hit) begin
                     state    <= LOST;
                     locked_o <= 1'b0;
                  end
               end
            end
            LOST: begin
`ifdef PRBS_CHK_RELOCK_EN
               state    <= SEED;
               seed_cnt <= '0;
`else
               done_o   <= 1'b1;
               pass_o   <= 1'b0;
`endif
            end
            DONE: ;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prbs_chk.sv
// Self-checking bench for prbs_chk: directed scenarios plus randomized streams
// compared against a bit-queue reference model of the checker.
`timescale 1ns/1ps
module tb_prbs_chk;

   localparam int unsigned DW = 8;
   localparam int unsigned NW = 16;
   localparam int unsigned LT = 4;
`ifdef PRBS_CHK_RELOCK_EN
   localparam bit RELOCK = 1'b1;
`else
   localparam bit RELOCK = 1'b0;
`endif

   localparam int P_IDLE  = 0;
   localparam int P_SEED  = 1;
   localparam int P_CHECK = 2;
   localparam int P_LOST  = 3;
   localparam int P_DONE  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_i = 1'b0;
   logic          valid_i = 1'b0;
   logic [DW-1:0] data_i = '0;
   logic          locked_o, done_o, pass_o;
   logic [31:0]   err_cnt_o;
   logic [15:0]   lost_cnt_o;
   logic [31:0]   word_cnt_o;

   int n_checks = 0;
   int n_fail   = 0;

   prbs_chk #(.DATA_W(DW), .NUM_WORDS(NW), .LOSS_THR(LT)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .valid_i    (valid_i),
      .data_i     (data_i),
      .locked_o   (locked_o),
      .done_o     (done_o),
      .pass_o     (pass_o),
      .err_cnt_o  (err_cnt_o),
      .lost_cnt_o (lost_cnt_o),
      .word_cnt_o (word_cnt_o)
   );

   always #5 clk = ~clk;

   // Stream source: bit history, oldest first; b[n] = b[n-15] ^ b[n-14].
   bit g_hist[$];

   task automatic gen_seed(input logic [14:0] s);
      g_hist.delete();
      for (int i = 14; i >= 0; i--) g_hist.push_back(s[i]);
   endtask

   task automatic gen_word(output logic [DW-1:0] w);
      bit nb;
      for (int i = int'(DW) - 1; i >= 0; i--) begin
         nb = g_hist[0] ^ g_hist[1];
         w[i] = nb;
         g_hist.push_back(nb);
         void'(g_hist.pop_front());
      end
   endtask

   // Reference model of the checker's observable behaviour.
   int     m_phase;
   bit     m_hist[$];
   int     m_seedn;
   longint m_err;
   int     m_lost;
   longint m_words;
   int     m_cons;
   bit     m_locked, m_done, m_pass;

   function automatic void model_clear();
      m_hist.delete();
      for (int i = 0; i < 15; i++) m_hist.push_back(1'b0);
      m_seedn = 0; m_err = 0; m_lost = 0; m_words = 0; m_cons = 0;
      m_locked = 0; m_done = 0; m_pass = 0;
   endfunction

   function automatic void model_reset();
      model_clear();
      m_phase = P_IDLE;
   endfunction

   function automatic void model_cycle(input bit st, input bit v, input logic [DW-1:0] d);
      int nerr;
      bit nb, any, lost_now;
      if (st) begin
         model_clear();
         m_phase = P_SEED;
         return;
      end
      case (m_phase)
         P_SEED: if (v) begin
            for (int i = int'(DW) - 1; i >= 0; i--) begin
               m_hist.push_back(d[i]);
               void'(m_hist.pop_front());
            end
            m_seedn++;
            if (m_seedn == int'((15 + DW - 1) / DW)) begin
               m_seedn = 0;
               any = 0;
               foreach (m_hist[i]) any |= m_hist[i];
               if (any) begin m_phase = P_CHECK; m_locked = 1; end
            end
         end
         P_CHECK: if (v) begin
            nerr = 0;
            for (int i = int'(DW) - 1; i >= 0; i--) begin
               nb = m_hist[0] ^ m_hist[1];
               m_hist.push_back(nb);
               void'(m_hist.pop_front());
               if (d[i] !== nb) nerr++;
            end
            m_err += nerr;
            if (m_err > 64'hFFFF_FFFF) m_err = 64'hFFFF_FFFF;
            m_words++;
            lost_now = 0;
            if (nerr > 0) begin
               m_cons++;
               if (m_cons == int'(LT)) begin
                  m_cons = 0;
                  lost_now = 1;
                  if (m_lost < 65535) m_lost++;
               end
            end else begin
               m_cons = 0;
            end
            if (m_words == longint'(NW)) begin
               m_phase = P_DONE; m_done = 1; m_locked = 0;
               m_pass = (m_err == 0) && (m_lost == 0);
            end else if (lost_now) begin
               m_phase = P_LOST; m_locked = 0;
            end
         end
         P_LOST: begin
            if (RELOCK) begin m_phase = P_SEED; m_seedn = 0; end
            else begin m_done = 1; m_pass = 0; end
         end
         default: ;
      endcase
   endfunction

   task automatic step(input bit st, input bit v, input logic [DW-1:0] d);
      start_i = st; valid_i = v; data_i = d;
      @(posedge clk);
      model_cycle(st, v, d);
      #1;
      start_i = 1'b0; valid_i = 1'b0; data_i = '0;
   endtask

   task automatic send_clean(input int n);
      logic [DW-1:0] w;
      for (int k = 0; k < n; k++) begin gen_word(w); step(1'b0, 1'b1, w); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (locked_o !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0b want 0", locked_o); end
      n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done_o); end
      n_checks++; if (pass_o !== 1'b0) begin n_fail++; $display("FAIL reset_pass: got %0b want 0", pass_o); end
      n_checks++; if (err_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_err: got %0d want 0", err_cnt_o); end
      n_checks++; if (lost_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_lost: got %0d want 0", lost_cnt_o); end
      n_checks++; if (word_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_words: got %0d want 0", word_cnt_o); end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_clean();
      logic [DW-1:0] w;
      step(1'b1, 1'b0, '0);
      gen_seed(15'h7FFF);
      gen_word(w); step(1'b0, 1'b1, w);
      n_checks++; if (locked_o !== 1'b0) begin n_fail++; $display("FAIL clean_lock_early: got %0b want 0", locked_o); end
      gen_word(w); step(1'b0, 1'b1, w);
      n_checks++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL clean_lock: got %0b want 1", locked_o); end
      send_clean(int'(NW) - 1);
      n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL clean_done_early: got %0b want 0", done_o); end
      send_clean(1);
      n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL clean_done: got %0b want 1", done_o); end
      n_checks++; if (pass_o !== 1'b1) begin n_fail++; $display("FAIL clean_pass: got %0b want 1", pass_o); end
      n_checks++; if (err_cnt_o !== 32'd0) begin n_fail++; $display("FAIL clean_err: got %0d want 0", err_cnt_o); end
      n_checks++; if (word_cnt_o !== 32'(NW)) begin n_fail++; $display("FAIL clean_words: got %0d want %0d", word_cnt_o, NW); end
      step(1'b0, 1'b1, 8'($urandom));
      n_checks++; if (word_cnt_o !== 32'(NW) || done_o !== 1'b1) begin n_fail++; $display("FAIL done_hold: got words=%0d done=%0b want %0d 1", word_cnt_o, done_o, NW); end
   endtask

   task automatic test_single_err();
      logic [DW-1:0] w;
      step(1'b1, 1'b0, '0);
      gen_seed(15'h7FFF);
      send_clean(2);
      for (int k = 0; k < int'(NW); k++) begin
         gen_word(w);
         if (k == 4) w ^= 8'h08;
         step(1'b0, 1'b1, w);
      end
      n_checks++; if (err_cnt_o !== 32'd1) begin n_fail++; $display("FAIL single_err: got %0d want 1", err_cnt_o); end
      n_checks++; if (lost_cnt_o !== 16'd0) begin n_fail++; $display("FAIL single_lost: got %0d want 0", lost_cnt_o); end
      n_checks++; if (done_o !== 1'b1 || pass_o !== 1'b0) begin n_fail++; $display("FAIL single_verdict: got done=%0b pass=%0b want 1 0", done_o, pass_o); end
   endtask

   task automatic test_loss();
      logic [DW-1:0] w;
      step(1'b1, 1'b0, '0);
      gen_seed(15'h7FFF);
      send_clean(2);
      send_clean(3);
      for (int k = 0; k < int'(LT); k++) begin
         gen_word(w); step(1'b0, 1'b1, w ^ 8'hFF);
      end
      n_checks++; if (lost_cnt_o !== 16'd1) begin n_fail++; $display("FAIL loss_cnt: got %0d want 1", lost_cnt_o); end
      n_checks++; if (locked_o !== 1'b0) begin n_fail++; $display("FAIL loss_unlock: got %0b want 0", locked_o); end
      n_checks++; if (err_cnt_o !== 32'd32) begin n_fail++; $display("FAIL loss_err: got %0d want 32", err_cnt_o); end
      step(1'b0, 1'b0, '0);
      if (RELOCK) begin
         n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL relock_done: got %0b want 0", done_o); end
         send_clean(1);
         n_checks++; if (locked_o !== 1'b0) begin n_fail++; $display("FAIL relock_early: got %0b want 0", locked_o); end
         send_clean(1);
         n_checks++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL relock_lock: got %0b want 1", locked_o); end
         send_clean(int'(NW) - 7);
         n_checks++; if (done_o !== 1'b1 || pass_o !== 1'b0) begin n_fail++; $display("FAIL relock_verdict: got done=%0b pass=%0b want 1 0", done_o, pass_o); end
         n_checks++; if (word_cnt_o !== 32'(NW) || lost_cnt_o !== 16'd1) begin n_fail++; $display("FAIL relock_counts: got words=%0d lost=%0d want %0d 1", word_cnt_o, lost_cnt_o, NW); end
      end else begin
         n_checks++; if (done_o !== 1'b1 || pass_o !== 1'b0 || locked_o !== 1'b0) begin n_fail++; $display("FAIL lost_terminal: got done=%0b pass=%0b lock=%0b want 1 0 0", done_o, pass_o, locked_o); end
         send_clean(3);
         n_checks++; if (word_cnt_o !== 32'd7 || done_o !== 1'b1) begin n_fail++; $display("FAIL lost_hold: got words=%0d done=%0b want 7 1", word_cnt_o, done_o); end
      end
   endtask

   task automatic test_all_zero();
      step(1'b1, 1'b0, '0);
      for (int k = 0; k < 12; k++) begin
         step(1'b0, 1'b1, '0);
         n_checks++;
         if (locked_o !== 1'b0 || word_cnt_o !== 32'd0 || done_o !== 1'b0) begin
            n_fail++; $display("FAIL all_zero[%0d]: got lock=%0b words=%0d done=%0b want 0 0 0", k, locked_o, word_cnt_o, done_o);
         end
      end
   endtask

   task automatic test_restart();
      logic [DW-1:0] w;
      step(1'b1, 1'b0, '0);
      gen_seed(15'h1234);
      send_clean(2);
      for (int k = 0; k < 7; k++) begin
         gen_word(w);
         if (k == 2) w ^= 8'h81;
         step(1'b0, 1'b1, w);
      end
      n_checks++; if (word_cnt_o !== 32'd7 || err_cnt_o !== 32'd2) begin n_fail++; $display("FAIL restart_pre: got words=%0d err=%0d want 7 2", word_cnt_o, err_cnt_o); end
      gen_word(w);
      step(1'b1, 1'b1, w);
      n_checks++; if (word_cnt_o !== 32'd0 || err_cnt_o !== 32'd0 || lost_cnt_o !== 16'd0) begin n_fail++; $display("FAIL restart_clear: got words=%0d err=%0d lost=%0d want 0 0 0", word_cnt_o, err_cnt_o, lost_cnt_o); end
      n_checks++; if (locked_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL restart_flags: got lock=%0b done=%0b want 0 0", locked_o, done_o); end
      send_clean(2);
      n_checks++; if (locked_o !== 1'b1 || word_cnt_o !== 32'd0) begin n_fail++; $display("FAIL restart_reseed: got lock=%0b words=%0d want 1 0", locked_o, word_cnt_o); end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] w;
      step(1'b1, 1'b0, '0);
      gen_seed(15'h2A5C);
      send_clean(2);
      gen_word(w); step(1'b0, 1'b1, w ^ 8'h10);
      send_clean(2);
      n_checks++; if (locked_o !== 1'b1 || err_cnt_o !== 32'd1) begin n_fail++; $display("FAIL midrst_pre: got lock=%0b err=%0d want 1 1", locked_o, err_cnt_o); end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (locked_o !== 1'b0 || done_o !== 1'b0 || pass_o !== 1'b0 || err_cnt_o !== 32'd0 ||
          lost_cnt_o !== 16'd0 || word_cnt_o !== 32'd0) begin
         n_fail++; $display("FAIL midrst_async: got lock=%0b done=%0b pass=%0b err=%0d lost=%0d words=%0d want all 0",
                            locked_o, done_o, pass_o, err_cnt_o, lost_cnt_o, word_cnt_o);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      send_clean(3);
      n_checks++; if (locked_o !== 1'b0 || word_cnt_o !== 32'd0) begin n_fail++; $display("FAIL midrst_idle: got lock=%0b words=%0d want 0 0", locked_o, word_cnt_o); end
   endtask

   task automatic test_random();
      logic [DW-1:0] w;
      int burst, after_done, r;
      for (int run = 0; run < 12; run++) begin
         gen_seed(15'($urandom_range(1, 32767)));
         step(1'b1, 1'b0, '0);
         if (run % 4 == 3) for (int k = 0; k < 3; k++) step(1'b0, 1'b1, '0);
         burst = 0;
         after_done = 0;
         for (int cyc = 0; cyc < 80 && after_done < 3; cyc++) begin
            r = int'($urandom_range(0, 99));
            if (r < 15) begin
               step(1'b0, 1'b0, 8'($urandom));
            end else begin
               gen_word(w);
               if (burst > 0) begin
                  w ^= 8'($urandom_range(1, 255)); burst--;
               end else if (r < 25) begin
                  w ^= 8'(1 << $urandom_range(0, DW - 1));
               end else if (r < 29) begin
                  burst = int'($urandom_range(LT - 1, LT));
               end
               step(r == 99, 1'b1, w);
            end
            n_checks++;
            if (locked_o !== m_locked || done_o !== m_done || pass_o !== m_pass ||
                err_cnt_o !== 32'(m_err) || lost_cnt_o !== 16'(m_lost) || word_cnt_o !== 32'(m_words)) begin
               n_fail++;
               $display("FAIL random run=%0d cyc=%0d: got lock=%0b done=%0b pass=%0b err=%0d lost=%0d words=%0d want %0b %0b %0b %0d %0d %0d",
                        run, cyc, locked_o, done_o, pass_o, err_cnt_o, lost_cnt_o, word_cnt_o,
                        m_locked, m_done, m_pass, m_err, m_lost, m_words);
            end
            if (m_done) after_done++;
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clean();
      test_single_err();
      test_loss();
      test_all_zero();
      test_restart();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
